// File: rtl/mux_sel_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux_sel_arbiter_pkg
// Shared definitions for the two-source round-robin arbiter that drives the
// select of the downstream 2:1 mux.
//   state_e      : arbiter state encoding (IDLE / grant to x / grant to y)
//   SEL_X, SEL_Y : mux select values steering source x or source y to out
//   grant_state  : maps a source index (0 = x, 1 = y) to its grant state
// ----------------------------------------------------------------------------
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  // Grant state owned by source 'src' (0 = x, 1 = y).
  function automatic state_e grant_state(input logic src);
    return src ? ST_G1 : ST_G0;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter.sv
// ----------------------------------------------------------------------------
// mux_sel_arbiter
// Two-requester round-robin arbiter sitting upstream of a 2:1 mux. It issues
// the mux select and one-hot grants so only one source is steered to the mux
// output at a time. A grant is held until the consumer signals done, the
// owner drops its request, or the hold budget runs out. Every output is a
// flop, so the mux select never glitches and no input reaches an output
// combinationally.
//
// Parameters
//   HOLD_MAX : max consecutive cycles a grant is held while the other source
//              waits (1 .. 2**CNT_W-1)
//   CNT_W    : width of the hold counter
//
// Ports
//   clk   in  : clock, rising edge
//   rst_n in  : synchronous active-low reset
//   req0  in  : source x requests the output
//   req1  in  : source y requests the output
//   done  in  : consumer finished with the current source
//   sel   out : mux select, 0 = x, 1 = y (holds its value while idle)
//   gnt0  out : grant to source x
//   gnt1  out : grant to source y
//   busy  out : a grant is active
// ----------------------------------------------------------------------------
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic done,
  output logic sel,
  output logic gnt0,
  output logic gnt1,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;   // source released most recently
  logic             sel_q, sel_d;
  logic             gnt0_q, gnt1_q, busy_q;

  logic             owner_s;          // current owner index while granting
  logic             owner_req_s;
  logic             other_req_s;
  logic             release_s;

  // Next-state logic: arbitration from IDLE and release/rotation from a grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_s     = 1'b0;
    owner_req_s = 1'b0;
    other_req_s = 1'b0;
    release_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done has no meaning without a grant and is ignored here.
        cnt_d = '0;
        if (req0 && req1) begin
          // Tie: favour the source that was not served last.
          state_d = grant_state(~last_q);
        end else if (req0) begin
          state_d = ST_G0;
        end else if (req1) begin
          state_d = ST_G1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_G0, ST_G1: begin
        owner_s     = (state_q == ST_G1);
        owner_req_s = owner_s ? req1 : req0;
        other_req_s = owner_s ? req0 : req1;
        // done, request drop and timeout collapse into one release event.
        release_s   = done | ~owner_req_s | (cnt_q == CNT_LAST);
        if (release_s) begin
          last_d = owner_s;
          cnt_d  = '0;
          if (other_req_s) begin
            // Hand over directly, without an idle bubble.
            state_d = grant_state(~owner_s);
          end else if (owner_req_s) begin
            // Nobody is waiting: re-grant the same source with a fresh budget.
            state_d = grant_state(owner_s);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          // Release fires at CNT_LAST, so the counter never wraps here.
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Select follows the next grant and keeps its value while idle.
  always_comb begin
    sel_d = sel_q;
    case (state_d)
      ST_G0:   sel_d = SEL_X;
      ST_G1:   sel_d = SEL_Y;
      default: sel_d = sel_q;
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;          // source x wins the first tie
      sel_q   <= SEL_X;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      // Outputs are decoded from the next state so the grant appears one
      // cycle after the request while still coming straight from flops.
      gnt0_q  <= (state_d == ST_G0);
      gnt1_q  <= (state_d == ST_G1);
      busy_q  <= (state_d == ST_G0) || (state_d == ST_G1);
    end
  end

  assign sel  = sel_q;
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Self-checking bench for mux_sel_arbiter (HOLD_MAX = 4). A behavioural model
// tracks which source owns the output and how many cycles it has held it;
// directed scenarios and a randomized run are compared against it.
// ----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic done = 1'b0;
  logic sel, gnt0, gnt1, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner -1 = nobody, 0 = x, 1 = y.
  int   m_owner = -1;
  int   m_held  = 0;   // cycles the current owner has had the output
  int   m_last  = 1;
  logic m_sel   = 1'b0;

  mux_sel_arbiter #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req0),
    .req1 (req1),
    .done (done),
    .sel  (sel),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_step();
    bit r[2];
    r[0] = req0;
    r[1] = req1;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_last = 1; m_sel = 1'b0;
    end else if (m_owner < 0) begin
      if (r[0] && r[1]) m_owner = 1 - m_last;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
      m_held = (m_owner < 0) ? 0 : 1;
    end else if (done || !r[m_owner] || m_held >= HOLD) begin
      m_last = m_owner;
      if (r[1 - m_owner])  begin m_owner = 1 - m_owner; m_held = 1; end
      else if (r[m_owner]) m_held = 1;
      else begin m_owner = -1; m_held = 0; end
    end else begin
      m_held = m_held + 1;
    end
    if (m_owner == 0) m_sel = 1'b0;
    else if (m_owner == 1) m_sel = 1'b1;
  endtask

  function automatic logic [3:0] model_vec();
    return {m_sel, m_owner == 0, m_owner == 1, m_owner >= 0};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({sel, gnt0, gnt1, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected 0000", i, {sel, gnt0, gnt1, busy});
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({sel, gnt0, gnt1, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_first_tie: got %b expected 0101", {sel, gnt0, gnt1, busy});
    end
  endtask

  task automatic test_single();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
    tick();
    rst_n = 1'b1; req1 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      done = (i == 3);
      tick();
      checks++;
      if ({sel, gnt0, gnt1, busy} !== 4'b1011 || model_vec() !== 4'b1011) begin
        errors++;
        $display("FAIL single_y[%0d]: got %b model %b expected 1011", i, {sel, gnt0, gnt1, busy}, model_vec());
      end
    end
    done = 1'b0; req1 = 1'b0;
    tick();
    checks++;
    if ({sel, gnt0, gnt1, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL single_drop: got %b expected 1000", {sel, gnt0, gnt1, busy});
    end
  endtask

  task automatic test_tie_rotation();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      done = (i % 2 == 1);
      tick();
      checks++;
      if ({sel, gnt0, gnt1, busy} !== model_vec() || (gnt0 && gnt1) || !busy) begin
        errors++;
        $display("FAIL tie_rotation[%0d]: got %b expected %b", i, {sel, gnt0, gnt1, busy}, model_vec());
      end
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_y;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; done = 1'b0; tick();
    rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_y = ((i / HOLD) % 2) == 1;
      checks++;
      if ({sel, gnt0, gnt1, busy} !== {exp_y, ~exp_y, exp_y, 1'b1} || model_vec() !== {exp_y, ~exp_y, exp_y, 1'b1}) begin
        errors++;
        $display("FAIL timeout[%0d]: got %b model %b expected %b", i, {sel, gnt0, gnt1, busy}, model_vec(), {exp_y, ~exp_y, exp_y, 1'b1});
      end
    end
  endtask

  task automatic test_no_contention();
    req0 = 1'b1; req1 = 1'b0; done = 1'b0;
    tick();   // finish any hand-over from the previous scenario
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({sel, gnt0, gnt1, busy} !== 4'b0101) begin
        errors++;
        $display("FAIL no_contention[%0d]: got %b expected 0101", i, {sel, gnt0, gnt1, busy});
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    req0 = 1'b0; req1 = 1'b1; done = 1'b0;
    tick(); tick();
    checks++;
    if ({sel, gnt0, gnt1, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL pre_reset_g1: got %b expected 1011", {sel, gnt0, gnt1, busy});
    end
    rst_n = 1'b0; done = 1'b1;
    tick();
    checks++;
    if ({sel, gnt0, gnt1, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_grant: got %b expected 0000", {sel, gnt0, gnt1, busy});
    end
    rst_n = 1'b1; req1 = 1'b0; done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sel, gnt0, gnt1, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_done_ignored[%0d]: got %b expected 0000", i, {sel, gnt0, gnt1, busy});
      end
    end
    done = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      done  = ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if ({sel, gnt0, gnt1, busy} !== model_vec() || (gnt0 && gnt1)) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, {sel, gnt0, gnt1, busy}, model_vec());
      end
    end
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_tie_rotation();
    test_timeout();
    test_no_contention();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Two-requester round-robin arbiter that sits directly upstream of the team's 2:1 mux.
- Generates the mux select (`sel`) plus per-source grants, so only one source (x or y) is steered to `out` at a time.
- Holds a grant until the consumer signals `done`, the requester drops, or a hold-timeout expires.
- All outputs are registered, so the mux select never glitches.

Parameters:
- `HOLD_MAX`, 4: max consecutive cycles a grant may be held while the other source waits; legal range 1..2^CNT_W-1.
- `CNT_W`, 3: width of the hold counter.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  synchronous active-low reset (decided: one clock; reset synchronous, active-low).
- `req0`  input  1  source x (mux input x) requests the output.
- `req1`  input  1  source y (mux input y) requests the output.
- `done`  input  1  consumer finished with the current source; releases the grant.
- `sel`  output  1  mux select: 0 = x, 1 = y.
- `gnt0`  output  1  grant to source x.
- `gnt1`  output  1  grant to source y.
- `busy`  output  1  high while any grant is active.

Behaviour:
- States: IDLE, G0, G1. All outputs are registered from the state.
- `gnt0` = (state==G0); `gnt1` = (state==G1); `busy` = gnt0|gnt1.
- `sel` = 1 in G1, 0 in G0; in IDLE, `sel` holds its last value (no toggle without a grant).
- Reset (`rst_n`=0 at a rising edge): state=IDLE, sel=0, gnt0=gnt1=busy=0, cnt=0, last=1 (so source 0 wins the first tie).
  - Reset mid-grant drops the grant at that same edge; no `done` is required.
- Latency: a request seen at edge N produces the grant at edge N (visible in the cycle after the request is sampled); one cycle from req to gnt.
- IDLE:
  - req0 & req1 -> grant the source != last.
  - only req0 -> G0; only req1 -> G1; neither -> stay IDLE.
  - `done` in IDLE is ignored.
- Gx (x = current owner), evaluated every edge:
  - cnt increments while in Gx and saturates at HOLD_MAX-1.
  - release = done | ~req_x | (cnt==HOLD_MAX-1).
  - No release -> stay in Gx.
  - On release, last := x, and:
    - other source requesting -> go directly to G(other), cnt=0 (no idle bubble).
    - else req_x still high -> stay in Gx, cnt=0 (re-grant; covers both done and timeout).
    - else -> IDLE, cnt=0.
- Timeout only forces rotation when the other source is waiting. With HOLD_MAX=1 and both requesting, the grant alternates every cycle.
- Simultaneous `done` and timeout: treated as a single release.
- req_x dropping and `done` in the same cycle: single release.
- gnt0 and gnt1 are never high together; exactly one is high when busy=1.
- No combinational path from any input to any output.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2) and SEL_X=1'b0, SEL_Y=1'b1.
- No sub-module needed. Optional integration wrapper `arb_mux2` instantiates `mux_sel_arbiter` plus the existing 2:1 mux (sel driven by the arbiter).

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req0=req1=1 -> gnt0=gnt1=busy=0, sel=0. Release reset -> next edge gnt0=1, sel=0.
2. Single requester: req1=1 only, done pulsed on cycle 3 -> gnt1=1 and sel=1 from cycle 1; after done, req1 still high -> G1 re-granted (gnt1 stays 1). Drop req1 -> IDLE next edge with sel held at 1.
3. Tie rotation: req0=req1=1 held, done pulsed every 2 cycles -> grants alternate G0, G1, G0, ...; gnt0 and gnt1 never both 1; no IDLE cycle between grants.
4. Timeout: HOLD_MAX=4, req0=req1=1, done=0 -> gnt0 held exactly 4 cycles, then gnt1 for 4 cycles, repeating.
5. Timeout without contention: req0=1, req1=0, done=0 for 10 cycles -> gnt0 stays 1 for all 10 cycles, sel=0 throughout.
6. Reset mid-grant, plus ignored done: in G1, assert rst_n=0 together with done=1 -> next edge all outputs at reset values, sel=0. Separately, done=1 while IDLE -> no state change.
